alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: none; the 32-bit datapath width is fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream holds a decoded-stage instruction.
REQ-005 in_ready  output  1  block can accept this cycle.
REQ-006 in_instr  input  32  RV32I instruction word.
REQ-007 in_pc  input  32  PC of in_instr.
REQ-008 in_rs1_data / in_rs2_data  input  32 each  register-file read values.
REQ-009 out_valid  output  1  issue packet available to ALU stage.
REQ-010 out_ready  input  1  ALU stage accepts the packet.
REQ-011 out_a / out_b  output  32 each  ALU operands (rs1 or PC or 0; rs2 or immediate).
REQ-012 out_func  output  3  ALU function code; out_control  output  1  SUB/SRA select.
REQ-013 out_rd  output  5  destination register; out_illegal  output  1  unsupported encoding.

Function
REQ-014 Transfer occurs on a rising edge with valid && ready on that side; out_* payload SHALL stay stable while out_valid && !out_ready.
REQ-015 Latency: an accepted instruction appears on out_* in the next cycle (one register stage).
REQ-016 OP (opcode 0110011): a=rs1, b=rs2, func=funct3, control=instr[30]; funct7 SHALL be 0000000, or 0100000 only with funct3 000/101; otherwise out_illegal=1.
REQ-017 OP-IMM (0010011): a=rs1, b=sign-extended instr[31:20], control=0; funct3 001 requires instr[31:25]=0; funct3 101 accepts instr[31:25] 0000000 (SRLI) or 0100000 (SRAI, control=1); for 001/101, b=zero-extended instr[24:20]; violations set out_illegal.
REQ-018 LUI (0110111): a=0, b={instr[31:12],12'b0}, func=000, control=0.
REQ-019 AUIPC (0010111): a=in_pc, b={instr[31:12],12'b0}, func=000, control=0.
REQ-020 Any other opcode, or an illegal variant: out_illegal=1, a=rs1, b=0, func=000, control=0, rd=instr[11:7]; the packet SHALL still be handshaken.
REQ-021 out_rd=instr[11:7] for all encodings.
REQ-022 Simultaneous accept and drain in one cycle SHALL sustain one instruction per cycle with no bubble.
REQ-023 When the block is empty, out_valid=0 and out_ready is ignored.

Reset
REQ-024 rst_n low SHALL immediately clear out_valid, all out_* payload to 0, and the skid entry (if present); in_ready=0 during reset.
REQ-025 Reset mid-transfer discards held packets; after release, in_ready=1 on the first clock.

Configuration
REQ-026 Macro ALU_ISSUE_SKID_EN defined: a 2-entry skid buffer; in_ready is a registered signal (=skid empty), and no combinational path runs out_ready->in_ready.
REQ-027 Without ALU_ISSUE_SKID_EN: single entry; in_ready = !out_valid || out_ready (combinational).
REQ-028 Both builds SHALL produce identical packet sequences for identical accepted input; only in_ready timing differs.

Structure
REQ-029 Package alu_issue_pkg holds opcode constants (OP, OP_IMM, LUI, AUIPC), ALU func codes (ADD=000 .. AND=111), and the packet struct typedef {a,b,func,control,rd,illegal}.
REQ-030 Combinational decode goes in sub-module alu_issue_decode (instr, pc, rs1, rs2 -> packet); alu_issue contains only handshake and registers.

Verification
REQ-031 in_instr=0x40208033 (SUB x0? rd=0,rs1=1,rs2=2), rs1=5, rs2=7, out_ready=1 -> next cycle a=5, b=7, func=000, control=1, illegal=0.
REQ-032 in_instr=0x4030D093 (SRAI x1,x1,3), rs1=0x80000000 -> b=3, func=101, control=1; b=0x00000003 with no sign bits.
REQ-033 LUI 0xABCDE0B7 -> a=0, b=0xABCDE000, rd=1; AUIPC with pc=0x100, imm=1 -> a=0x100, b=0x1000.
REQ-034 in_instr=0x0220C033 (funct7=0000001) -> out_illegal=1, b=0, packet handshaken.
REQ-035 Stream of 4 ADDIs with out_ready low for 3 cycles: no loss or duplication, payload held stable, order preserved; the skid build never shows in_ready combinationally dependent on out_ready.
REQ-036 Assert rst_n low while out_valid=1 and out_ready=0 -> out_valid=0 asynchronously; the first post-reset packet is the next accepted instruction.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: RV32I opcodes, ALU function codes and the issue packet.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_func_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_func_e   func;
    logic        control;
    logic [4:0]  rd;
    logic        illegal;
  } issue_pkt_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] zext5(input logic [4:0] v);
    return {27'b0, v};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Decode-to-ALU issue handshake bundle; slave is the issue stage, master drives it.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_func;
  logic        out_control;
  logic [4:0]  out_rd;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_func, out_control, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_func, out_control, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I ALU-class decode: instruction, PC and register values to an issue packet.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output issue_pkt_t  pkt
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = sext12(instr[31:20]);
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = zext5(instr[24:20]);

  // Defaults are the illegal-packet shape; each legal encoding overrides what it needs.
  always_comb begin
    pkt = '{a: rs1, b: '0, func: ALU_ADD, control: 1'b0, rd: instr[11:7], illegal: 1'b0};
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          pkt.b       = rs2;
          pkt.func    = alu_func_e'(funct3);
          pkt.control = instr[30];
        end else begin
          pkt.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) begin
              pkt.b    = shamt;
              pkt.func = ALU_SLL;
            end else begin
              pkt.illegal = 1'b1;
            end
          end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              pkt.b    = shamt;
              pkt.func = ALU_SR;
            end else if (funct7 == F7_ALT) begin
              pkt.b       = shamt;
              pkt.func    = ALU_SR;
              pkt.control = 1'b1;
            end else begin
              pkt.illegal = 1'b1;
            end
          end
          default: begin
            pkt.b    = imm_i;
            pkt.func = alu_func_e'(funct3);
          end
        endcase
      end
      OPC_LUI: begin
        pkt.a = '0;
        pkt.b = imm_u;
      end
      OPC_AUIPC: begin
        pkt.a = pc;
        pkt.b = imm_u;
      end
      default: begin
        pkt.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: one register stage between decode and ALU with valid/ready on both sides.
// Build option ALU_ISSUE_SKID_EN adds a skid entry so in_ready is registered.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  issue_pkt_t dec_pkt;
  issue_pkt_t out_q;
  logic       out_valid_q;
  logic       accept;
  logic       drain;

  alu_issue_decode u_decode (
    .instr (bus.in_instr),
    .pc    (bus.in_pc),
    .rs1   (bus.in_rs1_data),
    .rs2   (bus.in_rs2_data),
    .pkt   (dec_pkt)
  );

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = out_valid_q && bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_pkt_t skid_q;
  logic       skid_valid_q;

  // Ready depends only on the skid flag, so out_ready never reaches in_ready combinationally.
  assign bus.in_ready = rst_n && !skid_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (skid_valid_q) begin
      if (drain) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || bus.out_ready) begin
        out_q       <= dec_pkt;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= dec_pkt;
        skid_valid_q <= 1'b1;
      end
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end
`else
  assign bus.in_ready = rst_n && (!out_valid_q || bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      out_q       <= dec_pkt;
      out_valid_q <= 1'b1;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign bus.out_valid   = out_valid_q;
  assign bus.out_a       = out_q.a;
  assign bus.out_b       = out_q.b;
  assign bus.out_func    = out_q.func;
  assign bus.out_control = out_q.control;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed RV32I vectors, stalls and mid-transfer reset.
module tb_alu_issue;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  func;
    logic        ctl;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   pops;
  vec_t vecs[17];
  logic [73:0] sb[$];

  alu_issue_if bus ();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [73:0] exp_of(input vec_t v);
    return {v.a, v.b, v.func, v.ctl, v.rd, v.ill};
  endfunction

  function automatic logic [73:0] dut_pkt();
    return {bus.out_a, bus.out_b, bus.out_func, bus.out_control, bus.out_rd, bus.out_illegal};
  endfunction

  // Drives vectors first..first+n-1 back to back; cycles counts clock edges spent.
  task automatic stream(input int first, input int n, output int cycles);
    cycles = 0;
    for (int k = first; k < first + n; k++) begin
      bit took = 1'b0;
      bus.in_valid    = 1'b1;
      bus.in_instr    = vecs[k].instr;
      bus.in_pc       = vecs[k].pc;
      bus.in_rs1_data = vecs[k].rs1;
      bus.in_rs2_data = vecs[k].rs2;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (bus.in_ready) begin
          sb.push_back(exp_of(vecs[k]));
          took = 1'b1;
          break;
        end
        @(posedge clk);
        cycles++;
      end
      if (!took) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: vector %0d never accepted", k);
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_wait(input string name);
    bit empty = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    tests++;
    if (!empty) begin
      fails++;
      $display("FAIL %s: %0d packets outstanding, required 0", name, sb.size());
    end
    @(posedge clk);
    #1;
    check({name, "_idle"}, 74'(bus.out_valid), 74'(0));
  endtask

  // Monitor: compares every drained packet and holds payload steady across stalls.
  initial begin
    logic        held;
    logic [73:0] last;
    held = 1'b0;
    last = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else if (bus.out_valid) begin
        if (held) check("stall_stable", dut_pkt(), last);
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pkt: got %h expected none", dut_pkt());
          end else begin
            check("packet", dut_pkt(), sb.pop_front());
            pops++;
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          last = dut_pkt();
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic r0;
    tests = 0;
    fails = 0;
    pops  = 0;
    //         instr          pc            rs1           rs2           a             b             f     c     rd     ill
    vecs[0]  = '{32'h40208033, 32'h0,        32'h5,        32'h7,        32'h5,        32'h7,        3'd0, 1'b1, 5'd0,  1'b0};
    vecs[1]  = '{32'h4030D093, 32'h0,        32'h80000000, 32'h1234,     32'h80000000, 32'h3,        3'd5, 1'b1, 5'd1,  1'b0};
    vecs[2]  = '{32'hABCDE0B7, 32'h40,       32'h11,       32'h22,       32'h0,        32'hABCDE000, 3'd0, 1'b0, 5'd1,  1'b0};
    vecs[3]  = '{32'h00001117, 32'h100,      32'h33,       32'h44,       32'h100,      32'h1000,     3'd0, 1'b0, 5'd2,  1'b0};
    vecs[4]  = '{32'h0220C033, 32'h0,        32'h55,       32'h66,       32'h55,       32'h0,        3'd0, 1'b0, 5'd0,  1'b1};
    vecs[5]  = '{32'hFF016193, 32'h0,        32'hA5A5A5A5, 32'h1,        32'hA5A5A5A5, 32'hFFFFFFF0, 3'd6, 1'b0, 5'd3,  1'b0};
    vecs[6]  = '{32'h40009093, 32'h0,        32'h77,       32'h88,       32'h77,       32'h0,        3'd0, 1'b0, 5'd1,  1'b1};
    vecs[7]  = '{32'h0000A283, 32'h0,        32'h99,       32'h1,        32'h99,       32'h0,        3'd0, 1'b0, 5'd5,  1'b1};
    vecs[8]  = '{32'h40209033, 32'h0,        32'hAB,       32'hCD,       32'hAB,       32'h0,        3'd0, 1'b0, 5'd0,  1'b1};
    vecs[9]  = '{32'h01F15213, 32'h0,        32'hF0000000, 32'h2,        32'hF0000000, 32'h1F,       3'd5, 1'b0, 5'd4,  1'b0};
    vecs[10] = '{32'h0083C333, 32'h0,        32'h0F0F0F0F, 32'h00FF00FF, 32'h0F0F0F0F, 32'h00FF00FF, 3'd4, 1'b0, 5'd6,  1'b0};
    vecs[11] = '{32'h40B554B3, 32'h0,        32'hDEADBEEF, 32'h4,        32'hDEADBEEF, 32'h4,        3'd5, 1'b1, 5'd9,  1'b0};
    vecs[12] = '{32'h00108093, 32'h0,        32'h10,       32'h0,        32'h10,       32'h1,        3'd0, 1'b0, 5'd1,  1'b0};
    vecs[13] = '{32'h00208113, 32'h0,        32'h20,       32'h0,        32'h20,       32'h2,        3'd0, 1'b0, 5'd2,  1'b0};
    vecs[14] = '{32'hFFF08193, 32'h0,        32'h30,       32'h0,        32'h30,       32'hFFFFFFFF, 3'd0, 1'b0, 5'd3,  1'b0};
    vecs[15] = '{32'h7FF08213, 32'h0,        32'h40,       32'h0,        32'h40,       32'h7FF,      3'd0, 1'b0, 5'd4,  1'b0};
    vecs[16] = '{32'h002082B3, 32'h0,        32'h12345678, 32'h11111111, 32'h12345678, 32'h11111111, 3'd0, 1'b0, 5'd5,  1'b0};

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_instr    = '0;
    bus.in_pc       = '0;
    bus.in_rs1_data = '0;
    bus.in_rs2_data = '0;
    bus.out_ready   = 1'b0;

    #3;
    check("reset_in_ready", 74'(bus.in_ready), 74'(0));
    check("reset_out_valid", 74'(bus.out_valid), 74'(0));
    check("reset_payload", dut_pkt(), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", 74'(bus.in_ready), 74'(1));

    // Full-rate stream: twelve vectors must take exactly twelve cycles.
    bus.out_ready = 1'b1;
    stream(0, 12, cyc);
    check("no_bubble_cycles", 74'(cyc), 74'(12));
    drain_wait("drain_main");
    check("main_pops", 74'(pops), 74'(12));

    // Four ADDIs with the consumer stalled for three cycles.
    fork
      begin
        int c2;
        stream(12, 4, c2);
      end
      begin
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain_wait("drain_stall");
    check("stall_pops", 74'(pops), 74'(16));

`ifdef ALU_ISSUE_SKID_EN
    bus.out_ready = 1'b0;
    stream(0, 1, cyc);
    for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
    #1;
    r0 = bus.in_ready;
    bus.out_ready = 1'b1;
    #1;
    check("skid_ready_decoupled", 74'(bus.in_ready), 74'(r0));
    bus.out_ready = 1'b0;
    stream(1, 1, cyc);
`else
    r0 = 1'b0;
    bus.out_ready = 1'b0;
    stream(0, 1, cyc);
`endif

    // Reset while a packet is held: everything must clear without a clock.
    for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
    check("held_before_reset", 74'(bus.out_valid), 74'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_valid", 74'(bus.out_valid), 74'(0));
    check("async_clear_payload", dut_pkt(), '0);
    check("async_in_ready", 74'(bus.in_ready), 74'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerelease_in_ready", 74'(bus.in_ready), 74'(1));
    check("rerelease_out_valid", 74'(bus.out_valid), 74'(0));
    bus.out_ready = 1'b1;
    stream(16, 1, cyc);
    drain_wait("drain_post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
